// File: rtl/sram_1rw_param.sv
// Parametrised single-port synchronous SRAM with per-lane write masking, 1- or 2-cycle
// read latency, a read-valid strobe and an optional post-reset memory clear sequencer.
module sram_1rw_param #(
    parameter int NUM_ADDR = 6,
    parameter int NUM_WORDS = 64,
    parameter int WORD_LENGTH = 128,
    parameter int MASK_GRAN = 8,
    parameter int RD_LAT = 1,
    parameter int INIT_ON_RESET = 1,
    parameter logic [WORD_LENGTH-1:0] INIT_VALUE = '0,
    localparam int NUM_LANES = WORD_LENGTH / MASK_GRAN
) (
    input  logic                   CE,
    input  logic                   RST,
    input  logic                   CSB,
    input  logic                   WEB,
    input  logic [NUM_ADDR-1:0]    A,
    input  logic [NUM_LANES-1:0]   BWEB,
    input  logic [WORD_LENGTH-1:0] I,
    input  logic                   OEB,
    output logic [WORD_LENGTH-1:0] O,
    output logic                   RVLD,
    output logic                   BUSY
);

    localparam int AW1 = NUM_ADDR + 1;
    localparam logic [NUM_ADDR-1:0] LAST_ADDR = NUM_ADDR'(NUM_WORDS - 1);
    localparam logic [AW1-1:0] WORDS_EXT = AW1'(NUM_WORDS);

    typedef enum logic {ST_INIT, ST_IDLE} state_t;

    state_t                 state_q;
    logic                   busy_q;
    logic [NUM_ADDR-1:0]    cnt_q;
    logic [NUM_ADDR-1:0]    cnt_d;
    logic [WORD_LENGTH-1:0] mem [NUM_WORDS];
    logic [WORD_LENGTH-1:0] dataOut_q;
    logic [WORD_LENGTH-1:0] rdWord;
    logic                   rvld_q;
    logic                   addrInRange;
    logic                   accept;
    logic                   writeAcc;
    logic                   readAcc;

    // Depth need not be a power of two, so addresses past the last word are screened out.
    assign addrInRange = {1'b0, A} < WORDS_EXT;
    assign accept      = !CSB && !busy_q && !RST;
    assign writeAcc    = accept && !WEB && addrInRange;
    assign readAcc     = accept && WEB;
    assign rdWord      = addrInRange ? mem[A] : '0;
    assign cnt_d       = cnt_q + 1'b1;

    always_ff @(posedge CE) begin
        if (RST) begin
            state_q <= (INIT_ON_RESET != 0) ? ST_INIT : ST_IDLE;
            busy_q  <= (INIT_ON_RESET != 0);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_d;
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // The array itself is never reset; only the clear sequencer or accepted writes touch it.
    always_ff @(posedge CE) begin
        if (!RST) begin
            if (state_q == ST_INIT) begin
                mem[cnt_q] <= INIT_VALUE;
            end else if (writeAcc) begin
                for (int k = 0; k < NUM_LANES; k++) begin
                    if (!BWEB[k]) begin
                        mem[A][k*MASK_GRAN +: MASK_GRAN] <= I[k*MASK_GRAN +: MASK_GRAN];
                    end
                end
            end
        end
    end

    if (RD_LAT == 2) begin : gLat2
        logic [WORD_LENGTH-1:0] stage_q;
        logic                   stageVld_q;

        always_ff @(posedge CE) begin
            if (RST) begin
                stage_q    <= '0;
                stageVld_q <= 1'b0;
                dataOut_q  <= '0;
                rvld_q     <= 1'b0;
            end else begin
                stageVld_q <= readAcc;
                if (readAcc) begin
                    stage_q <= rdWord;
                end
                rvld_q <= stageVld_q;
                if (stageVld_q) begin
                    dataOut_q <= stage_q;
                end
            end
        end
    end else begin : gLat1
        always_ff @(posedge CE) begin
            if (RST) begin
                dataOut_q <= '0;
                rvld_q    <= 1'b0;
            end else begin
                rvld_q <= readAcc;
                if (readAcc) begin
                    dataOut_q <= rdWord;
                end
            end
        end
    end

    assign O    = OEB ? {WORD_LENGTH{1'bz}} : dataOut_q;
    assign RVLD = rvld_q;
    assign BUSY = busy_q;

endmodule
